// File: rtl/i2c_mon_pkg.sv
// Shared state encoding and error-cause codes for the I2C sequence matcher.
package i2c_mon_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DATA      = 3'd1,
      ACK       = 3'd2,
      WAIT_STOP = 3'd3,
      FAIL      = 3'd4
   } state_e;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_DATA  = 2'd1;
   localparam logic [1:0] ERR_NACK  = 2'd2;
   localparam logic [1:0] ERR_FRAME = 2'd3;

endpackage

// File: rtl/i2c_line_cond.sv
// Synchronises raw scl/sda and derives START, STOP and BITCLK strobes.
// Strobes are combinational from the last two synchronised samples (SYNC_STAGES cycles after the pin).
module i2c_line_cond #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic start_o,
   output logic stop_o,
   output logic bitclk_o,
   output logic sda_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_cur;
   logic                   sda_cur;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
         sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   assign scl_cur = scl_sync_q[SYNC_STAGES-1];
   assign sda_cur = sda_sync_q[SYNC_STAGES-1];

   assign start_o  = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
   assign stop_o   = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;
   // A frame condition always wins over a clock edge seen in the same cycle.
   assign bitclk_o = ~scl_prev_q & scl_cur & ~start_o & ~stop_o;
   assign sda_o    = sda_cur;

endmodule

// File: rtl/i2c_seq_matcher.sv
// Passive I2C monitor: checks each transaction against a masked byte pattern, ACKs and closing STOP.
// Pulses appear SYNC_STAGES+1 cycles after the pin edge; never drives the bus.
module i2c_seq_matcher
   import i2c_mon_pkg::*;
#(
   parameter  int NUM_BYTES   = 4,
   parameter  int SYNC_STAGES = 2,
   parameter  int CNT_W       = 16,
   localparam int IDX_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   scl,
   input  logic                   sda,
   input  logic [8*NUM_BYTES-1:0] pattern,
   input  logic [8*NUM_BYTES-1:0] mask,
   output logic                   match,
   output logic                   mismatch,
   output logic [1:0]             err_code,
   output logic [IDX_W-1:0]       byte_idx,
   output logic                   busy,
   output logic [2:0]             state,
   output logic [CNT_W-1:0]       match_count
);

   logic start_s, stop_s, bit_s, sda_s;

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
      .clk_i    (clk),
      .reset_i  (reset),
      .scl_i    (scl),
      .sda_i    (sda),
      .start_o  (start_s),
      .stop_o   (stop_s),
      .bitclk_o (bit_s),
      .sda_o    (sda_s)
   );

   state_e                 state_q;
   logic [8*NUM_BYTES-1:0] pat_q, mask_q;
   logic [6:0]             shift_q;
   logic [2:0]             bit_cnt_q;
   logic [IDX_W-1:0]       byte_idx_q;
   logic [1:0]             err_q;
   logic                   match_q, mismatch_q;
   logic [CNT_W-1:0]       count_q;
   logic [7:0]             byte_nxt;
   logic                   byte_ok;

   // Latched pattern/mask shift left per byte, so the current byte always sits in the MSBs.
   assign byte_nxt = {shift_q, sda_s};
   assign byte_ok  = ((byte_nxt ^ pat_q[8*NUM_BYTES-1 -: 8]) & mask_q[8*NUM_BYTES-1 -: 8]) == 8'h00;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pat_q      <= '0;
         mask_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_idx_q <= '0;
         err_q      <= ERR_NONE;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         count_q    <= '0;
      end else begin
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         if (!en) begin
            state_q <= IDLE;
         end else if (start_s) begin
            state_q    <= DATA;
            pat_q      <= pattern;
            mask_q     <= mask;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            err_q      <= ERR_NONE;
         end else begin
            case (state_q)
               DATA: begin
                  if (stop_s) begin
                     state_q    <= IDLE;
                     mismatch_q <= 1'b1;
                     err_q      <= ERR_FRAME;
                  end else if (bit_s) begin
                     shift_q   <= byte_nxt[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (byte_ok) begin
                           state_q <= ACK;
                        end else begin
                           state_q    <= FAIL;
                           mismatch_q <= 1'b1;
                           err_q      <= ERR_DATA;
                        end
                     end
                  end
               end
               ACK: begin
                  if (stop_s) begin
                     state_q    <= IDLE;
                     mismatch_q <= 1'b1;
                     err_q      <= ERR_FRAME;
                  end else if (bit_s) begin
                     if (sda_s) begin
                        state_q    <= FAIL;
                        mismatch_q <= 1'b1;
                        err_q      <= ERR_NACK;
                     end else if (byte_idx_q == IDX_W'(NUM_BYTES - 1)) begin
                        state_q <= WAIT_STOP;
                     end else begin
                        state_q    <= DATA;
                        byte_idx_q <= byte_idx_q + IDX_W'(1);
                        bit_cnt_q  <= '0;
                        pat_q      <= pat_q << 8;
                        mask_q     <= mask_q << 8;
                     end
                  end
               end
               WAIT_STOP: begin
                  if (stop_s) begin
                     state_q <= IDLE;
                     match_q <= 1'b1;
                     if (count_q != '1) count_q <= count_q + CNT_W'(1);
                  end else if (bit_s) begin
                     state_q    <= FAIL;
                     mismatch_q <= 1'b1;
                     err_q      <= ERR_FRAME;
                  end
               end
               FAIL: begin
                  if (stop_s) state_q <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign match       = match_q;
   assign mismatch    = mismatch_q;
   assign err_code    = err_q;
   assign byte_idx    = byte_idx_q;
   assign busy        = (state_q != IDLE);
   assign state       = state_q;
   assign match_count = count_q;

endmodule

// File: tb/tb_i2c_seq_matcher.sv
// Scenario bench for i2c_seq_matcher: bit-banged I2C stimulus, pulse scoreboard, per-task status checks.
module tb_i2c_seq_matcher;
   import i2c_mon_pkg::*;

   localparam int NB = 2;
   localparam int SS = 2;
   localparam int CW = 3;
   localparam int IW = 1;
   localparam int Q  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b1;
   logic scl = 1'b1;
   logic sda = 1'b1;
   logic [8*NB-1:0] pattern = 16'h90A5;
   logic [8*NB-1:0] mask    = 16'hFFFF;
   logic            match, mismatch, busy;
   logic [1:0]      err_code;
   logic [IW-1:0]   byte_idx;
   logic [2:0]      state;
   logic [CW-1:0]   match_count;

   typedef struct packed {
      logic          is_match;
      logic [1:0]    err;
      logic [IW-1:0] idx;
   } ev_t;

   ev_t           sb[$];
   int            errors = 0;
   int            checks = 0;
   logic [CW-1:0] exp_count = '0;

   i2c_seq_matcher #(.NUM_BYTES(NB), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .en(en), .scl(scl), .sda(sda),
      .pattern(pattern), .mask(mask), .match(match), .mismatch(mismatch),
      .err_code(err_code), .byte_idx(byte_idx), .busy(busy), .state(state),
      .match_count(match_count)
   );

   always #5 clk = ~clk;

   // Every observed pulse is matched against the oldest expected event.
   always @(negedge clk) begin
      ev_t e;
      if (match || mismatch) begin
         checks++;
         if (match && mismatch) begin
            errors++;
            $display("FAIL both_pulses got match=1 mismatch=1, need at most one");
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got match=%0b mismatch=%0b err=%0d, need no pulse",
                     match, mismatch, err_code);
         end else begin
            e = sb.pop_front();
            if (match !== e.is_match ||
                (mismatch && (err_code !== e.err || byte_idx !== e.idx))) begin
               errors++;
               $display("FAIL pulse_kind got match=%0b err=%0d idx=%0d, need match=%0b err=%0d idx=%0d",
                        match, err_code, byte_idx, e.is_match, e.err, e.idx);
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_match();
      sb.push_back('{is_match: 1'b1, err: ERR_NONE, idx: IW'(NB - 1)});
      if (exp_count != '1) exp_count++;
   endtask

   task automatic push_mismatch(input logic [1:0] err, input logic [IW-1:0] idx);
      sb.push_back('{is_match: 1'b0, err: err, idx: idx});
   endtask

   // Each bit leaves scl high so a STOP can follow with a single sda rise.
   task automatic bit_rise(input logic b);
      scl = 1'b0; wait_clk(Q);
      sda = b;    wait_clk(Q);
      scl = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bit_rise(b[i]);
   endtask

   task automatic i2c_start();
      scl = 1'b1; sda = 1'b1; wait_clk(Q);
      sda = 1'b0; wait_clk(Q);
   endtask

   task automatic rep_start();
      scl = 1'b0; wait_clk(Q);
      sda = 1'b1; wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      sda = 1'b0; wait_clk(Q);
   endtask

   task automatic stop_now();
      sda = 1'b1; wait_clk(Q);
   endtask

   task automatic stop_general();
      scl = 1'b0; wait_clk(Q);
      sda = 1'b0; wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      sda = 1'b1; wait_clk(Q);
   endtask

   task automatic good_txn();
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      send_byte(8'hA5); bit_rise(1'b0);
      push_match();
      stop_now();
   endtask

   task automatic end_txn(input string name, input logic [1:0] exp_err);
      wait_clk(4 * Q);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got %0d outstanding events, need 0", name, sb.size());
         sb.delete();
      end
      checks++;
      if (state !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle got state=%0d busy=%0b, need state=0 busy=0", name, state, busy);
      end
      checks++;
      if (err_code !== exp_err) begin
         errors++;
         $display("FAIL %s_err got %0d, need %0d", name, err_code, exp_err);
      end
      checks++;
      if (match_count !== exp_count) begin
         errors++;
         $display("FAIL %s_count got %0d, need %0d", name, match_count, exp_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; wait_clk(3);
      checks++;
      if (state !== 3'd0 || busy !== 1'b0 || match !== 1'b0 || mismatch !== 1'b0 ||
          err_code !== 2'd0 || byte_idx !== '0 || match_count !== '0) begin
         errors++;
         $display("FAIL reset_state got st=%0d busy=%0b m=%0b mm=%0b err=%0d idx=%0d cnt=%0d, need all 0",
                  state, busy, match, mismatch, err_code, byte_idx, match_count);
      end
      reset = 1'b0; wait_clk(Q);
   endtask

   task automatic test_match();
      i2c_start();
      wait_clk(Q);
      pattern = 16'h0000;
      checks++;
      if (state !== 3'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_data got state=%0d busy=%0b, need state=1 busy=1", state, busy);
      end
      send_byte(8'h90); bit_rise(1'b0);
      send_byte(8'hA5); bit_rise(1'b0);
      checks++;
      if (state !== 3'd3) begin
         errors++;
         $display("FAIL wait_stop got state=%0d, need 3", state);
      end
      push_match();
      stop_now();
      pattern = 16'h90A5;
      end_txn("match", ERR_NONE);
   endtask

   task automatic test_data_mismatch();
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      push_mismatch(ERR_DATA, 1'b1);
      send_byte(8'hA4);
      wait_clk(Q);
      checks++;
      if (state !== 3'd4) begin
         errors++;
         $display("FAIL data_fail_state got %0d, need 4", state);
      end
      stop_general();
      end_txn("data", ERR_DATA);
   endtask

   task automatic test_masked_match();
      mask = 16'hFFFE;
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      send_byte(8'hA4); bit_rise(1'b0);
      push_match();
      stop_now();
      mask = 16'hFFFF;
      end_txn("masked", ERR_NONE);
   endtask

   task automatic test_nack();
      i2c_start();
      send_byte(8'h90);
      push_mismatch(ERR_NACK, 1'b0);
      bit_rise(1'b1);
      stop_general();
      end_txn("nack", ERR_NACK);
   endtask

   task automatic test_short();
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      push_mismatch(ERR_FRAME, 1'b1);
      stop_now();
      end_txn("short", ERR_FRAME);
   endtask

   task automatic test_overlong();
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      send_byte(8'hA5); bit_rise(1'b0);
      push_mismatch(ERR_FRAME, 1'b1);
      bit_rise(1'b1);
      stop_general();
      end_txn("overlong", ERR_FRAME);
   endtask

   task automatic test_back_to_back();
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      bit_rise(1'b1); bit_rise(1'b0); bit_rise(1'b1);
      rep_start();
      send_byte(8'h90); bit_rise(1'b0);
      send_byte(8'hA5); bit_rise(1'b0);
      push_match();
      stop_now();
      end_txn("repstart", ERR_NONE);
      good_txn();
      end_txn("b2b", ERR_NONE);
   endtask

   task automatic test_sda_glitch();
      scl = 1'b0; wait_clk(Q);
      for (int i = 0; i < 4; i++) begin
         sda = ~sda; wait_clk(Q);
      end
      scl = 1'b1; wait_clk(Q);
      sda = 1'b1; wait_clk(Q);
      end_txn("sda_low_scl", ERR_NONE);
   endtask

   task automatic test_enable();
      en = 1'b0;
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      send_byte(8'hA5); bit_rise(1'b0);
      stop_now();
      end_txn("disabled", ERR_NONE);
      en = 1'b1;
   endtask

   task automatic test_reset_mid();
      i2c_start();
      send_byte(8'h90); bit_rise(1'b0);
      bit_rise(1'b1); bit_rise(1'b0); bit_rise(1'b1);
      reset = 1'b1;
      scl = 1'b1; sda = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      exp_count = '0;
      end_txn("reset_mid", ERR_NONE);
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 7; i++) good_txn();
      end_txn("count_max", ERR_NONE);
      checks++;
      if (match_count !== 3'd7) begin
         errors++;
         $display("FAIL count_all_ones got %0d, need 7", match_count);
      end
      good_txn();
      end_txn("saturate", ERR_NONE);
   endtask

   initial begin
      test_reset();
      test_match();
      test_data_mismatch();
      test_masked_match();
      test_nack();
      test_short();
      test_overlong();
      test_back_to_back();
      test_sda_glitch();
      test_enable();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
